// File: rtl/layer_router_pp.sv
`default_nettype none
// ============================================================================
// Module   : layer_router_pp
// Purpose  : Ping-pong router between one user port, NPROC processor ports and
//            two single-port synchronous caches, with a drained bank swap.
// Revision : 1.0
// ============================================================================
module layer_router_pp #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int NPROC   = 2,
    parameter int LAYER_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      critical,
    input  logic                      reverse_write,
    input  logic                      swap_req,
    output logic                      swap_done,
    output logic                      bank_sel,
    output logic [LAYER_W-1:0]        layer_cnt,
    input  logic                      user_req,
    input  logic                      user_we,
    input  logic [ADDR_W-1:0]         user_addr,
    input  logic [DATA_W-1:0]         user_din,
    output logic                      user_gnt,
    output logic [DATA_W-1:0]         user_dout,
    output logic                      user_valid,
    input  logic [NPROC-1:0]          proc_req,
    input  logic [NPROC-1:0]          proc_we,
    input  logic [NPROC*ADDR_W-1:0]   proc_addr,
    input  logic [NPROC*DATA_W-1:0]   proc_din,
    output logic [NPROC-1:0]          proc_gnt,
    output logic [NPROC*DATA_W-1:0]   proc_dout,
    output logic [NPROC-1:0]          proc_valid,
    output logic [ADDR_W-1:0]         cache0_addr,
    output logic [DATA_W-1:0]         cache0_din,
    output logic                      cache0_we,
    input  logic [DATA_W-1:0]         cache0_dout,
    output logic [ADDR_W-1:0]         cache1_addr,
    output logic [DATA_W-1:0]         cache1_din,
    output logic                      cache1_we,
    input  logic [DATA_W-1:0]         cache1_dout
);

    localparam int PTR_W = (NPROC > 1) ? $clog2(NPROC) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAIN  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_bank_sel;
    logic [LAYER_W-1:0]        r_layer;
    logic [PTR_W-1:0]          r_ptr;
    logic                      r_u_rd;
    logic                      r_u_bank;
    logic [DATA_W-1:0]         r_u_hold;
    logic [NPROC-1:0]          r_p_rd;
    logic                      r_p_bank;
    logic [NPROC*DATA_W-1:0]   r_p_hold;

    logic                      w_pend;
    logic                      w_enter_commit;
    logic                      w_rd_issue;
    logic [NPROC-1:0]          w_pgnt;
    logic                      w_pany;
    logic [PTR_W-1:0]          w_pidx;
    logic [PTR_W-1:0]          w_ptr_nxt;
    logic                      w_pwe;
    logic [ADDR_W-1:0]         w_paddr;
    logic [DATA_W-1:0]         w_pdin;
    logic                      w_pbank;
    logic [DATA_W-1:0]         w_u_data;
    logic [DATA_W-1:0]         w_p_data;
    int                        w_j;

    assign w_pend = (r_state != S_IDLE);

    // Grants are gated by rst_n so nothing reaches the caches while in reset.
    assign user_gnt = rst_n & user_req & ~critical & ~reverse_write & ~w_pend;

    always_comb begin
        w_pgnt  = '0;
        w_pany  = 1'b0;
        w_pidx  = '0;
        w_pwe   = 1'b0;
        w_paddr = '0;
        w_pdin  = '0;
        w_j     = 0;
        if (rst_n && !w_pend) begin
            for (int k = 0; k < NPROC; k++) begin
                w_j = int'(r_ptr) + k;
                if (w_j >= NPROC) begin
                    w_j = w_j - NPROC;
                end
                if (!w_pany && proc_req[w_j]) begin
                    w_pany        = 1'b1;
                    w_pgnt[w_j]   = 1'b1;
                    w_pidx        = PTR_W'(w_j);
                    w_pwe         = proc_we[w_j];
                    w_paddr       = proc_addr[w_j*ADDR_W +: ADDR_W];
                    w_pdin        = proc_din[w_j*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign proc_gnt   = w_pgnt;
    assign w_ptr_nxt  = (w_pidx == PTR_W'(NPROC - 1)) ? '0 : w_pidx + 1'b1;
    // Reverse-write steers only processor writes into the user bank.
    assign w_pbank    = (w_pwe & reverse_write) ? r_bank_sel : ~r_bank_sel;
    assign w_rd_issue = (user_gnt & ~user_we) | (w_pany & ~w_pwe);

    always_comb begin
        cache0_addr = '0;
        cache0_din  = '0;
        cache0_we   = 1'b0;
        cache1_addr = '0;
        cache1_din  = '0;
        cache1_we   = 1'b0;
        if (w_pany) begin
            if (w_pbank) begin
                cache1_addr = w_paddr;
                cache1_din  = w_pdin;
                cache1_we   = w_pwe;
            end else begin
                cache0_addr = w_paddr;
                cache0_din  = w_pdin;
                cache0_we   = w_pwe;
            end
        end
        if (user_gnt) begin
            if (r_bank_sel) begin
                cache1_addr = user_addr;
                cache1_din  = user_din;
                cache1_we   = user_we;
            end else begin
                cache0_addr = user_addr;
                cache0_din  = user_din;
                cache0_we   = user_we;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (swap_req) begin
                    w_state_nxt = w_rd_issue ? S_DRAIN : S_COMMIT;
                end
            end
            S_DRAIN:  w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign w_enter_commit = (w_state_nxt == S_COMMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_sel <= 1'b0;
            r_layer    <= '0;
            r_ptr      <= '0;
            r_u_rd     <= 1'b0;
            r_u_bank   <= 1'b0;
            r_u_hold   <= '0;
            r_p_rd     <= '0;
            r_p_bank   <= 1'b0;
            r_p_hold   <= '0;
        end else begin
            if (w_enter_commit) begin
                r_bank_sel <= ~r_bank_sel;
                r_layer    <= r_layer + 1'b1;
            end
            if (w_pany) begin
                r_ptr <= w_ptr_nxt;
            end
            r_u_rd   <= user_gnt & ~user_we;
            r_u_bank <= r_bank_sel;
            r_p_rd   <= (w_pany & ~w_pwe) ? w_pgnt : '0;
            r_p_bank <= w_pbank;
            if (r_u_rd) begin
                r_u_hold <= w_u_data;
            end
            for (int i = 0; i < NPROC; i++) begin
                if (r_p_rd[i]) begin
                    r_p_hold[i*DATA_W +: DATA_W] <= w_p_data;
                end
            end
        end
    end

    // Returning data is picked by the bank tag captured at issue, so a swap
    // committing right behind a read still routes it from the original bank.
    assign w_u_data   = r_u_bank ? cache1_dout : cache0_dout;
    assign w_p_data   = r_p_bank ? cache1_dout : cache0_dout;
    assign user_valid = r_u_rd;
    assign user_dout  = r_u_rd ? w_u_data : r_u_hold;
    assign proc_valid = r_p_rd;

    generate
        for (genvar g = 0; g < NPROC; g++) begin : g_pout
            assign proc_dout[g*DATA_W +: DATA_W] =
                r_p_rd[g] ? w_p_data : r_p_hold[g*DATA_W +: DATA_W];
        end
    endgenerate

    assign swap_done = (r_state == S_COMMIT);
    assign bank_sel  = r_bank_sel;
    assign layer_cnt = r_layer;

endmodule
`default_nettype wire

// File: tb/tb_layer_router_pp.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_router_pp
// Purpose  : Directed self-checking bench for layer_router_pp (NPROC=2).
// Revision : 1.0
// ============================================================================
module tb_layer_router_pp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        critical, reverse_write, swap_req;
    logic        swap_done, bank_sel;
    logic [7:0]  layer_cnt;
    logic        user_req, user_we, user_gnt, user_valid;
    logic [15:0] user_addr, user_din, user_dout;
    logic [1:0]  proc_req, proc_we, proc_gnt, proc_valid;
    logic [31:0] proc_addr, proc_din, proc_dout;
    logic [15:0] cache0_addr, cache0_din, cache0_dout;
    logic [15:0] cache1_addr, cache1_din, cache1_dout;
    logic        cache0_we, cache1_we;

    int n_chk  = 0;
    int n_fail = 0;
    int n_pulse;
    logic [1:0] exp_alt [4];

    always #5 clk = ~clk;

    layer_router_pp #(.DATA_W(16), .ADDR_W(16), .NPROC(2), .LAYER_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .critical(critical), .reverse_write(reverse_write),
        .swap_req(swap_req), .swap_done(swap_done), .bank_sel(bank_sel), .layer_cnt(layer_cnt),
        .user_req(user_req), .user_we(user_we), .user_addr(user_addr), .user_din(user_din),
        .user_gnt(user_gnt), .user_dout(user_dout), .user_valid(user_valid),
        .proc_req(proc_req), .proc_we(proc_we), .proc_addr(proc_addr), .proc_din(proc_din),
        .proc_gnt(proc_gnt), .proc_dout(proc_dout), .proc_valid(proc_valid),
        .cache0_addr(cache0_addr), .cache0_din(cache0_din), .cache0_we(cache0_we),
        .cache0_dout(cache0_dout),
        .cache1_addr(cache1_addr), .cache1_din(cache1_din), .cache1_we(cache1_we),
        .cache1_dout(cache1_dout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; critical = 1'b0; reverse_write = 1'b0; swap_req = 1'b0;
        user_req = 1'b1; user_we = 1'b1; user_addr = '0; user_din = '0;
        proc_req = 2'b11; proc_we = 2'b00; proc_addr = '0; proc_din = '0;
        cache0_dout = '0; cache1_dout = '0;
        exp_alt = '{2'b01, 2'b10, 2'b01, 2'b10};

        mid();
        chk("rst_bank_sel", bank_sel, 1'b0);
        chk("rst_layer_cnt", layer_cnt, 8'd0);
        chk("rst_swap_done", swap_done, 1'b0);
        chk("rst_user_gnt", user_gnt, 1'b0);
        chk("rst_proc_gnt", proc_gnt, 2'b00);
        chk("rst_cache0_we", cache0_we, 1'b0);
        chk("rst_cache1_we", cache1_we, 1'b0);
        chk("rst_valids", {user_valid, proc_valid}, 3'b000);

        nxt(); rst_n = 1'b1; user_req = 1'b0; proc_req = 2'b00;

        // User write to bank 0 alongside proc0 read from bank 1
        nxt();
        user_req = 1'b1; user_we = 1'b1; user_addr = 16'h0010; user_din = 16'hAAAA;
        proc_req = 2'b01; proc_we = 2'b00; proc_addr = {16'h0000, 16'h0020};
        cache1_dout = 16'hDDDD;
        mid();
        chk("t1_user_gnt", user_gnt, 1'b1);
        chk("t1_proc_gnt", proc_gnt, 2'b01);
        chk("t1_c0", {cache0_addr, cache0_din, cache0_we}, {16'h0010, 16'hAAAA, 1'b1});
        chk("t1_c1", {cache1_addr, cache1_we}, {16'h0020, 1'b0});

        nxt(); user_req = 1'b0; proc_req = 2'b00;
        mid();
        chk("t1_proc_valid", proc_valid, 2'b01);
        chk("t1_proc_dout0", proc_dout[15:0], 16'hDDDD);
        chk("t1_user_valid", user_valid, 1'b0);

        nxt(); cache1_dout = 16'h0000;
        mid();
        chk("hold_valid", proc_valid, 2'b00);
        chk("hold_dout0", proc_dout[15:0], 16'hDDDD);

        // Round robin
        for (int c = 0; c < 2; c++) begin
            nxt(); proc_req = 2'b10;
            mid();
            chk("rr_p1_only", proc_gnt, 2'b10);
        end
        for (int c = 0; c < 4; c++) begin
            nxt(); proc_req = 2'b11;
            mid();
            chk("rr_alt", proc_gnt, exp_alt[c]);
        end

        // Critical locks out the user only
        nxt();
        proc_req = 2'b01; critical = 1'b1;
        user_req = 1'b1; user_we = 1'b1; user_addr = 16'h0077; user_din = 16'h7777;
        mid();
        chk("crit_user_gnt", user_gnt, 1'b0);
        chk("crit_cache0", {cache0_addr, cache0_we}, {16'h0000, 1'b0});
        chk("crit_proc_gnt", proc_gnt, 2'b01);

        // Reverse write: proc write lands in the user bank (cache0)
        nxt();
        critical = 1'b0; reverse_write = 1'b1;
        proc_req = 2'b10; proc_we = 2'b10;
        proc_addr = {16'h0005, 16'h0000}; proc_din = {16'hCCCC, 16'h0000};
        mid();
        chk("rev_user_gnt", user_gnt, 1'b0);
        chk("rev_proc_gnt", proc_gnt, 2'b10);
        chk("rev_c0", {cache0_addr, cache0_din, cache0_we}, {16'h0005, 16'hCCCC, 1'b1});
        chk("rev_c1_we", cache1_we, 1'b0);

        nxt();
        proc_req = 2'b01; proc_we = 2'b00; proc_addr = {16'h0000, 16'h0030};
        cache1_dout = 16'h1234;
        mid();
        chk("rev_rd_gnt", proc_gnt, 2'b01);
        chk("rev_rd_c1", {cache1_addr, cache1_we}, {16'h0030, 1'b0});
        chk("rev_rd_c0_we", cache0_we, 1'b0);
        chk("rev_wr_no_valid", proc_valid, 2'b00);

        // Swap with a read issued in the request cycle
        nxt();
        reverse_write = 1'b0; user_req = 1'b0;
        proc_req = 2'b01; proc_addr = {16'h0000, 16'h0040}; swap_req = 1'b1;
        mid();
        chk("sw_rev_valid", proc_valid, 2'b01);
        chk("sw_rev_dout0", proc_dout[15:0], 16'h1234);
        chk("sw_gnt", proc_gnt, 2'b01);
        chk("sw_done0", swap_done, 1'b0);

        nxt();
        proc_req = 2'b11; user_req = 1'b1; user_we = 1'b1; cache1_dout = 16'hBEEF;
        mid();
        chk("drain_pgnt", proc_gnt, 2'b00);
        chk("drain_ugnt", user_gnt, 1'b0);
        chk("drain_valid", proc_valid, 2'b01);
        chk("drain_dout0", proc_dout[15:0], 16'hBEEF);
        chk("drain_state", {swap_done, bank_sel}, 2'b00);

        nxt(); swap_req = 1'b0;
        mid();
        chk("commit_pgnt", proc_gnt, 2'b00);
        chk("commit_ugnt", user_gnt, 1'b0);
        chk("commit_state", {swap_done, bank_sel, layer_cnt}, {1'b1, 1'b1, 8'd1});

        nxt();
        proc_req = 2'b00; user_req = 1'b1; user_we = 1'b1;
        user_addr = 16'h0011; user_din = 16'h5555;
        mid();
        chk("post_done", swap_done, 1'b0);
        chk("post_ugnt", user_gnt, 1'b1);
        chk("post_c1", {cache1_addr, cache1_din, cache1_we}, {16'h0011, 16'h5555, 1'b1});
        chk("post_c0_we", cache0_we, 1'b0);

        // Swap with nothing outstanding commits the next cycle
        nxt(); user_req = 1'b0; swap_req = 1'b1;
        nxt(); swap_req = 1'b0;
        mid();
        chk("fast_swap", {swap_done, bank_sel, layer_cnt}, {1'b1, 1'b0, 8'd2});

        n_pulse = 0;
        for (int s = 0; s < 254; s++) begin
            nxt(); swap_req = 1'b1;
            nxt(); swap_req = 1'b0;
            mid();
            if (swap_done) n_pulse++;
        end
        chk("wrap_pulses", n_pulse, 254);
        chk("wrap_state", {bank_sel, layer_cnt}, {1'b0, 8'd0});

        nxt(); swap_req = 1'b1;
        nxt(); swap_req = 1'b0;
        mid();
        chk("extra_swap", {bank_sel, layer_cnt}, {1'b1, 8'd1});

        // Reset during a drain
        nxt(); proc_req = 2'b01; proc_we = 2'b00; swap_req = 1'b1;
        mid();
        chk("rm_gnt", proc_gnt, 2'b01);
        nxt(); swap_req = 1'b0; proc_req = 2'b00; rst_n = 1'b0;
        mid();
        chk("rm_state", {swap_done, bank_sel, layer_cnt}, {1'b0, 1'b0, 8'd0});
        chk("rm_valid", proc_valid, 2'b00);
        nxt(); rst_n = 1'b1;
        nxt();
        mid();
        chk("rm_after", {swap_done, bank_sel}, 2'b00);

        // User read from bank 0
        nxt(); user_req = 1'b1; user_we = 1'b0; user_addr = 16'h0009;
        mid();
        chk("ur_c0", {user_gnt, cache0_addr, cache0_we}, {1'b1, 16'h0009, 1'b0});
        nxt(); user_req = 1'b0; cache0_dout = 16'h4321;
        mid();
        chk("ur_valid", user_valid, 1'b1);
        chk("ur_dout", user_dout, 16'h4321);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/layer_router_pp.md
Name: layer_router_pp

Overview:
- Parametrised ping-pong router between one user port, NPROC processor ports and two single-port synchronous caches (cache0/cache1).
- The user side loads the next layer into one bank while the processors share the other bank.
- A drained swap handshake exchanges bank roles and counts layers.
- Reverse-write mode lets the processors read layer k from the processor bank and write layer k+1 into the user bank.

Parameters:
DATA_W, 16, data width of all data buses
ADDR_W, 16, address width of all address buses
NPROC, 2, number of processor ports (>=1)
LAYER_W, 8, width of layer counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
critical  in  1  1 = user port locked out
reverse_write  in  1  1 = proc writes go to user bank, proc reads to proc bank; user locked out
swap_req  in  1  one-cycle request to exchange bank roles
swap_done  out  1  one-cycle pulse when swap takes effect
bank_sel  out  1  current user bank index (proc bank = ~bank_sel)
layer_cnt  out  LAYER_W  completed swaps, wraps
user_req/user_we  in  1  user access request / write enable
user_addr  in  ADDR_W  user address
user_din  in  DATA_W  user write data
user_gnt  out  1  user access accepted this cycle
user_dout  out  DATA_W  user read data
user_valid  out  1  user_dout valid
proc_req/proc_we  in  NPROC  per-proc request / write enable
proc_addr  in  NPROC*ADDR_W  flattened, proc i at [i*ADDR_W +: ADDR_W]
proc_din  in  NPROC*DATA_W  flattened write data
proc_gnt  out  NPROC  one-hot grant (or zero)
proc_dout  out  NPROC*DATA_W  flattened read data
proc_valid  out  NPROC  per-proc read data valid
cacheN_addr  out  ADDR_W  address to cache N (N=0,1)
cacheN_din  out  DATA_W  write data to cache N
cacheN_we  out  1  write enable to cache N
cacheN_dout  in  DATA_W  cache N read data, one cycle after address

Behaviour:
- Reset (async, rst_n=0): bank_sel=0, layer_cnt=0, swap_done=0, swap pending=0, RR pointer=0, all read tags cleared. user_valid=0, proc_valid=0. Grants and cache we are 0 while in reset.
- User bank = cache[bank_sel]; proc bank = cache[~bank_sel].
- user_gnt = user_req & ~critical & ~reverse_write & ~pending. When the user port is granted, it drives the user bank. A blocked user holds its request; there is no queueing.
- Processor arbitration: at most one proc_gnt per cycle (combinational from registered state), suppressed while pending. Round robin: search starts at the pointer; after a grant to i, pointer <= (i+1) mod NPROC. With no grant, the pointer holds.
- Granted proc target:
  - reads always go to the proc bank;
  - writes go to the proc bank when reverse_write=0 and to the user bank when reverse_write=1.
- Cache with no granted master: addr=0, din=0, we=0. we is asserted only for granted writes.
- Read latency: a read granted in cycle N gives valid and data in N+1. The port's valid bit and a registered bank tag select cacheN_dout combinationally. Writes produce no valid. proc_dout/user_dout hold their last value when not valid.
- Swap state machine:
  - IDLE: swap_req -> set pending.
  - DRAIN: pending=1, no new grants. If no read is outstanding, the swap commits next edge; otherwise it waits one cycle for the read to return.
  - COMMIT: bank_sel toggles, layer_cnt increments (wraps at 2^LAYER_W), swap_done=1 for exactly one cycle, pending clears. Return to IDLE.
- Timing: swap_req with nothing outstanding commits at the next edge (swap_done visible in the cycle after swap_req). With a read outstanding, it commits one cycle later.
- swap_req while pending is ignored; no second swap is queued.
- Mode changes (critical, reverse_write) take effect on the same cycle's grants. Outstanding reads always complete to the original requester and bank.
- Reset mid-swap or mid-read: pending and tags are discarded, and no swap_done or valid is emitted.

Test Plan:
- Defaults: NPROC=2, critical=0, reverse_write=0. user writes 16'hAAAA @16'h0010 while proc0 reads @16'h0020, cache1_dout=16'hDDDD → cache0_addr=16'h0010, cache0_din=16'hAAAA, cache0_we=1, cache1_addr=16'h0020, cache1_we=0; next cycle proc_valid[0]=1 with proc_dout[0]=16'hDDDD.
- proc0 and proc1 request continuously for 4 cycles → grants alternate 01,10,01,10; only proc1 requesting → grant 10 every cycle.
- critical=1 with user_req=1 → user_gnt=0, cache0_we=0; proc grants unaffected.
- reverse_write=1, bank_sel=0: proc1 writes 16'hCCCC @16'h0005 → cache0_addr=16'h0005, cache0_din=16'hCCCC, cache0_we=1. In the same mode, a proc0 read → cache1.
- swap_req with a proc read outstanding → no grants for 2 cycles, the outstanding read returns, then swap_done=1 for one cycle, bank_sel=1, layer_cnt=1. A subsequent user write → cache1.
- 256 swaps at LAYER_W=8 → layer_cnt wraps to 0. rst_n=0 in the cycle after swap_req → no swap_done, bank_sel=0.
